// File: rtl/sensor_monitor.sv
// sensor_monitor: multi-channel sensor fault monitor with persistence, first-fault record and event count
module sensor_monitor #(
   parameter int NUM_CH  = 4,
   parameter int PERSIST = 3,
   parameter bit STICKY  = 1,
   parameter int CNT_W   = 8,
   localparam int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [4*NUM_CH-1:0] sensors,
   input  logic                clear,
   output logic [NUM_CH-1:0]   status,
   output logic                error,
   output logic                first_valid,
   output logic [ID_W-1:0]     first_id,
   output logic [CNT_W-1:0]    event_count
);
   localparam int PW = $clog2(PERSIST + 1);

   logic [NUM_CH-1:0] raw, new_ev, live_nxt;
   logic [PW-1:0]     pcnt [NUM_CH];
   logic [ID_W-1:0]   ev_id;
   logic              any_ev;

   // raw fault rule, qualification and lowest-index event channel
   always_comb begin
      raw      = '0;
      new_ev   = '0;
      live_nxt = '0;
      ev_id    = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         raw[i]      = sensors[4*i] | (sensors[4*i+1] & (sensors[4*i+2] | sensors[4*i+3]));
         new_ev[i]   = raw[i] && pcnt[i] == PW'(PERSIST - 1);
         live_nxt[i] = raw[i] && pcnt[i] >= PW'(PERSIST - 1);
         if (new_ev[i]) ev_id = ID_W'(i);
      end
   end

   assign any_ev = |new_ev;
   assign error  = |status;

   // persistence counters: zero on raw low, saturate at PERSIST; untouched by clear
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++)
         pcnt[i] <= (rst || !raw[i]) ? '0 : (pcnt[i] == PW'(PERSIST)) ? pcnt[i] : pcnt[i] + 1'b1;
   end

   // status flags: latched with clear (new events win) or live tracking
   always_ff @(posedge clk) begin
      if (rst) status <= '0;
      else     status <= STICKY ? ((clear ? '0 : status) | new_ev) : live_nxt;
   end

   // first-fault record and saturating event counter; an event on a clear edge restarts both
   always_ff @(posedge clk) begin
      if (rst) begin
         first_valid <= 1'b0;
         first_id    <= '0;
         event_count <= '0;
      end else begin
         if (any_ev && (clear || !first_valid)) begin
            first_valid <= 1'b1;
            first_id    <= ev_id;
         end else if (clear) begin
            first_valid <= 1'b0;
            first_id    <= '0;
         end
         event_count <= clear ? CNT_W'(any_ev) : event_count + CNT_W'(any_ev && event_count != '1);
      end
   end
endmodule

// File: tb/tb_sensor_monitor.sv
// tb_sensor_monitor: directed checks of sensor_monitor in sticky, live and narrow-counter configurations
module tb_sensor_monitor;
   logic clk = 0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic [15:0] sa, sb, sc;
   logic        ra, rb, rc, ca, cb, cc;
   logic [3:0]  sta, stb, stc;
   logic        ea, eb, ec, fva, fvb, fvc;
   logic [1:0]  fia, fib, fic;
   logic [7:0]  cnta, cntb;
   logic [1:0]  cntc;

   sensor_monitor #(.NUM_CH(4), .PERSIST(3), .STICKY(1), .CNT_W(8)) dut_a (
      .clk(clk), .rst(ra), .sensors(sa), .clear(ca), .status(sta), .error(ea),
      .first_valid(fva), .first_id(fia), .event_count(cnta));
   sensor_monitor #(.NUM_CH(4), .PERSIST(1), .STICKY(0), .CNT_W(8)) dut_b (
      .clk(clk), .rst(rb), .sensors(sb), .clear(cb), .status(stb), .error(eb),
      .first_valid(fvb), .first_id(fib), .event_count(cntb));
   sensor_monitor #(.NUM_CH(4), .PERSIST(3), .STICKY(1), .CNT_W(2)) dut_c (
      .clk(clk), .rst(rc), .sensors(sc), .clear(cc), .status(stc), .error(ec),
      .first_valid(fvc), .first_id(fic), .event_count(cntc));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      sa = 0; sb = 0; sc = 0; ca = 0; cb = 0; cc = 0;
      ra = 1; rb = 1; rc = 1;
      tick(2);
      ra = 0; rb = 0; rc = 0;
      chk("rst_status", sta, 0);
      chk("rst_error", ea, 0);
      chk("rst_fv", fva, 0);
      chk("rst_fid", fia, 0);
      chk("rst_cnt", cnta, 0);

      // single channel, sticky, PERSIST=3
      sa = 16'h0100;
      tick(2);
      chk("a_pre_status", sta, 0);
      chk("a_pre_cnt", cnta, 0);
      tick();
      chk("a_status", sta, 4'b0100);
      chk("a_error", ea, 1);
      chk("a_fv", fva, 1);
      chk("a_fid", fia, 2);
      chk("a_cnt", cnta, 1);
      sa = 0;
      tick(2);
      chk("a_hold_status", sta, 4'b0100);
      chk("a_hold_cnt", cnta, 1);

      ca = 1; tick(); ca = 0;
      chk("a_clr_status", sta, 0);
      chk("a_clr_fv", fva, 0);
      chk("a_clr_cnt", cnta, 0);

      // glitch rejection and s[1]-alone non-fault
      sa = 16'h0006; tick(2); sa = 0; tick();
      chk("glitch_status", sta, 0);
      chk("glitch_cnt", cnta, 0);
      sa = 16'h0002; tick(10);
      chk("s1_status", sta, 0);
      chk("s1_cnt", cnta, 0);

      // simultaneous channels 1 and 3
      sa = 16'h1010; tick(3);
      chk("sim_status", sta, 4'b1010);
      chk("sim_fid", fia, 1);
      chk("sim_cnt", cnta, 1);

      // clear colliding with a new event on channel 0
      sa = 0; ca = 1; tick(); ca = 0;
      sa = 16'h0100; tick(3);
      chk("col_pre_status", sta, 4'b0100);
      chk("col_pre_fid", fia, 2);
      sa = 16'h0101; tick(2);
      ca = 1; tick(); ca = 0;
      chk("col_status", sta, 4'b0001);
      chk("col_fv", fva, 1);
      chk("col_fid", fia, 0);
      chk("col_cnt", cnta, 1);

      // sticky: no re-trigger after clear while raw stays high
      ca = 1; tick(); ca = 0;
      tick(4);
      chk("noretrig_status", sta, 0);
      chk("noretrig_cnt", cnta, 0);

      // live mode, PERSIST=1: 4 high, 1 low, 2 high on group 3
      sb = 16'h1000; tick();
      chk("b_on1_status", stb, 4'b1000);
      chk("b_on1_cnt", cntb, 1);
      tick(3);
      chk("b_on4_status", stb, 4'b1000);
      sb = 0; tick();
      chk("b_off_status", stb, 0);
      chk("b_off_error", eb, 0);
      sb = 16'h1000; tick();
      chk("b_re_status", stb, 4'b1000);
      chk("b_re_cnt", cntb, 2);
      tick();
      chk("b_re2_status", stb, 4'b1000);
      cb = 1; tick(); cb = 0;
      chk("b_clr_status", stb, 4'b1000);
      chk("b_clr_cnt", cntb, 0);
      chk("b_clr_fv", fvb, 0);

      // counter saturation with CNT_W=2
      for (int n = 1; n <= 5; n++) begin
         sc = 16'h0001; tick(3);
         sc = 0; tick();
         chk($sformatf("sat_cnt%0d", n), cntc, (n > 3) ? 3 : n);
      end
      chk("sat_status", stc, 4'b0001);

      // reset in mid-persistence
      sc = 16'h0010; tick(2);
      rc = 1; tick(); rc = 0;
      chk("midrst_status", stc, 0);
      chk("midrst_fv", fvc, 0);
      chk("midrst_cnt", cntc, 0);
      tick(2);
      chk("midrst_wait_status", stc, 0);
      tick();
      chk("midrst_q_status", stc, 4'b0010);
      chk("midrst_q_fid", fic, 1);
      chk("midrst_q_cnt", cntc, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
